// File: rtl/fpu_mul_pkg.sv
// Shared definitions for the single-precision multiplier controller and its datapath.
package fpu_mul_pkg;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 3;

    // Acceptance edge to first out_valid cycle on the arithmetic path.
    localparam int LAT_NORMAL     = MUL_CYCLES_DEF + 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXP  = 3'd1,
        MUL  = 3'd2,
        NORM = 3'd3,
        RND  = 3'd4,
        EUP  = 3'd5,
        DONE = 3'd6
    } state_e;

endpackage

// File: rtl/fpu_mul_ctrl.sv
// Sequencing controller for the multiplier datapath: walks operand latch, iterative
// multiply, normalize, round and exponent update, then holds the result for handoff.
module fpu_mul_ctrl
    import fpu_mul_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_special,
    input  logic flush,
    output logic ld_op,
    output logic mul_start,
    output logic mul_en,
    output logic norm_en,
    output logic rnd_en,
    output logic eup_en,
    input  logic ovf_case,
    input  logic udf_case,
    output logic out_valid,
    input  logic out_ready,
    output logic out_special,
    output logic res_ovf,
    output logic res_udf,
    input  logic clr_sticky,
    output logic ovf_sticky,
    output logic udf_sticky,
    output logic busy
);

    generate
        if (MUL_CYCLES < 1 || (MUL_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
            $error("fpu_mul_ctrl: MUL_CYCLES must be in 1..2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       out_special_q, out_special_d;
    logic       res_ovf_q, res_ovf_d;
    logic       res_udf_q, res_udf_d;
    logic       ovf_sticky_q, ovf_sticky_d;
    logic       udf_sticky_q, udf_sticky_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_special_q <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_udf_q     <= 1'b0;
            ovf_sticky_q  <= 1'b0;
            udf_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_special_q <= out_special_d;
            res_ovf_q     <= res_ovf_d;
            res_udf_q     <= res_udf_d;
            ovf_sticky_q  <= ovf_sticky_d;
            udf_sticky_q  <= udf_sticky_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_special_d = out_special_q;
        res_ovf_d     = res_ovf_q;
        res_udf_d     = res_udf_q;
        in_ready      = 1'b0;
        ld_op         = 1'b0;
        mul_start     = 1'b0;
        mul_en        = 1'b0;
        norm_en       = 1'b0;
        rnd_en        = 1'b0;
        eup_en        = 1'b0;
        out_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = ~flush;
                if (in_valid && !flush) begin
                    ld_op     = 1'b1;
                    res_ovf_d = 1'b0;
                    res_udf_d = 1'b0;
                    if (in_special) begin
                        state_d       = DONE;
                        out_special_d = 1'b1;
                    end else begin
                        state_d       = EXP;
                        out_special_d = 1'b0;
                    end
                end
            end
            EXP: begin
                cnt_d   = CNT_LOAD;
                state_d = MUL;
            end
            MUL: begin
                // The counter starts at MUL_CYCLES-1, so only the first beat sees the load value.
                mul_en    = 1'b1;
                mul_start = (cnt_q == CNT_LOAD);
                if (cnt_q == '0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NORM: begin
                norm_en = 1'b1;
                state_d = RND;
            end
            RND: begin
                rnd_en  = 1'b1;
                state_d = EUP;
            end
            EUP: begin
                eup_en    = 1'b1;
                res_ovf_d = ovf_case;
                res_udf_d = udf_case;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats both handshakes; the datapath must not see any enable this cycle.
        if (flush) begin
            state_d       = IDLE;
            ld_op         = 1'b0;
            mul_start     = 1'b0;
            mul_en        = 1'b0;
            norm_en       = 1'b0;
            rnd_en        = 1'b0;
            eup_en        = 1'b0;
            out_special_d = 1'b0;
            res_ovf_d     = 1'b0;
            res_udf_d     = 1'b0;
        end

        // A fresh exception on the EUP edge outranks a coincident clear.
        ovf_sticky_d = (ovf_sticky_q & ~clr_sticky) | (eup_en & ovf_case);
        udf_sticky_d = (udf_sticky_q & ~clr_sticky) | (eup_en & udf_case);
    end

    assign out_special = out_special_q;
    assign res_ovf     = res_ovf_q;
    assign res_udf     = res_udf_q;
    assign ovf_sticky  = ovf_sticky_q;
    assign udf_sticky  = udf_sticky_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_mul_ctrl.sv
// Scoreboard bench for fpu_mul_ctrl: queued expected results are compared on each handoff.
module tb_fpu_mul_ctrl;
    import fpu_mul_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0, in_special = 1'b0, flush = 1'b0;
    logic ovf_case = 1'b0, udf_case = 1'b0, out_ready = 1'b0, clr_sticky = 1'b0;
    logic in_ready, ld_op, mul_start, mul_en, norm_en, rnd_en, eup_en;
    logic out_valid, out_special, res_ovf, res_udf, ovf_sticky, udf_sticky, busy;

    typedef struct packed {
        logic special;
        logic ovf;
        logic udf;
    } result_t;

    result_t expQ[$];
    int nChecks = 0;
    int nFails  = 0;

    localparam logic [13:0] RESET_VEC = 14'b10_0000_0000_0000;

    fpu_mul_ctrl #(.MUL_CYCLES(MUL_CYCLES_DEF), .CNT_W(CNT_W_DEF)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_special(in_special), .flush(flush),
        .ld_op(ld_op), .mul_start(mul_start), .mul_en(mul_en), .norm_en(norm_en),
        .rnd_en(rnd_en), .eup_en(eup_en), .ovf_case(ovf_case), .udf_case(udf_case),
        .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
        .res_ovf(res_ovf), .res_udf(res_udf), .clr_sticky(clr_sticky),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [13:0] outVec();
        return {in_ready, ld_op, mul_start, mul_en, norm_en, rnd_en, eup_en,
                out_valid, out_special, res_ovf, res_udf, ovf_sticky, udf_sticky, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Handoffs are judged a little after the falling edge so same-edge input changes are settled.
    always begin
        @(negedge CLK);
        #2;
        if (!RST) begin
            checkOutput("enable onehot", 32'($countones({mul_en, norm_en, rnd_en, eup_en}) <= 1), 1);
            if (out_valid && out_ready && !flush) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected result", 1, 0);
                end else begin
                    result_t e;
                    e = expQ.pop_front();
                    checkOutput("out_special", out_special, e.special);
                    checkOutput("res_ovf", res_ovf, e.ovf);
                    checkOutput("res_udf", res_udf, e.udf);
                end
            end
        end
    end

    task automatic applyStimulus(input logic special, input logic ovf, input logic udf,
                                 input int holdCycles, input logic clrAtEup);
        int lat, nMul, nStart, nNorm, nRnd, nEup;
        @(posedge CLK); #1;
        in_valid = 1'b1; in_special = special; ovf_case = ovf; udf_case = udf; out_ready = 1'b0;
        @(negedge CLK);
        checkOutput("in_ready at accept", in_ready, 1);
        checkOutput("ld_op at accept", ld_op, 1);
        expQ.push_back('{special, special ? 1'b0 : ovf, special ? 1'b0 : udf});
        @(posedge CLK); #1;
        in_valid = 1'b0; in_special = 1'b1;
        lat = 1; nMul = 0; nStart = 0; nNorm = 0; nRnd = 0; nEup = 0;
        @(negedge CLK);
        while (!out_valid && lat < 40) begin
            checkOutput("ld_op outside idle", ld_op, 0);
            nMul += int'(mul_en); nStart += int'(mul_start);
            nNorm += int'(norm_en); nRnd += int'(rnd_en); nEup += int'(eup_en);
            if (eup_en) clr_sticky = clrAtEup;
            @(posedge CLK); #1;
            clr_sticky = 1'b0;
            lat++;
            @(negedge CLK);
        end
        in_special = 1'b0;
        checkOutput("latency", lat, special ? 1 : LAT_NORMAL);
        checkOutput("mul_en cycles", nMul, special ? 0 : MUL_CYCLES_DEF);
        checkOutput("mul_start cycles", nStart, special ? 0 : 1);
        checkOutput("norm/rnd/eup cycles", {8'(nNorm), 8'(nRnd), 8'(nEup)},
                    special ? 24'h0 : 24'h010101);
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput("held out_valid", out_valid, 1);
            checkOutput("held result", {out_special, res_ovf, res_udf},
                        expQ.size() > 0 ? 32'(expQ[0]) : 32'hdead);
            @(posedge CLK); #1;
            @(negedge CLK);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        @(negedge CLK);
        checkOutput("in_ready after handoff", {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt, extra;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkOutput("reset outputs", outVec(), RESET_VEC);

        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1'b0);
        checkOutput("udf_sticky set", udf_sticky, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 1'b0);
        checkOutput("udf_sticky kept", {ovf_sticky, udf_sticky}, 2'b11);

        // Flush in the second multiply beat.
        @(posedge CLK); #1;
        in_valid = 1'b1; ovf_case = 1'b0; udf_case = 1'b0;
        @(negedge CLK);
        checkOutput("ld_op before flush", ld_op, 1);
        @(posedge CLK); #1; in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1; flush = 1'b1;
        @(negedge CLK);
        checkOutput("flush gates mul", {mul_en, mul_start, busy}, 3'b001);
        @(posedge CLK); #1; flush = 1'b0;
        @(negedge CLK);
        checkOutput("idle after flush", {busy, in_ready}, 2'b01);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            extra += int'(mul_en | norm_en | rnd_en | eup_en | out_valid);
            @(negedge CLK);
        end
        checkOutput("no activity after flush", extra, 0);

        // Flush alongside a new request in IDLE.
        @(posedge CLK); #1; in_valid = 1'b1; flush = 1'b1;
        @(negedge CLK);
        checkOutput("flush blocks accept", {ld_op, in_ready}, 2'b00);
        @(posedge CLK); #1; in_valid = 1'b0; flush = 1'b0;
        @(negedge CLK);
        checkOutput("still idle", busy, 0);

        // Flush in DONE with out_ready high: result is discarded.
        @(posedge CLK); #1; in_valid = 1'b1; ovf_case = 1'b1;
        @(posedge CLK); #1; in_valid = 1'b0;
        cnt = 0;
        @(negedge CLK);
        while (!out_valid && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        checkOutput("reached done", out_valid, 1);
        checkOutput("ovf before flush", res_ovf, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1; flush = 1'b0; out_ready = 1'b0; ovf_case = 1'b0;
        @(negedge CLK);
        checkOutput("flush in done", {out_valid, res_ovf, busy}, 3'b000);

        // Explicit clear, then clear coinciding with an overflow EUP.
        @(posedge CLK); #1; clr_sticky = 1'b1;
        @(posedge CLK); #1; clr_sticky = 1'b0;
        @(negedge CLK);
        checkOutput("sticky cleared", {ovf_sticky, udf_sticky}, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1);
        checkOutput("set beats clear", {ovf_sticky, udf_sticky}, 2'b10);

        // Synchronous reset during the round stage.
        @(posedge CLK); #1; in_valid = 1'b1; udf_case = 1'b1;
        @(posedge CLK); #1; in_valid = 1'b0;
        cnt = 0;
        @(negedge CLK);
        while (!rnd_en && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        checkOutput("reached rnd", rnd_en, 1);
        RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0; udf_case = 1'b0;
        @(negedge CLK);
        checkOutput("reset mid-op", outVec(), RESET_VEC);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1'b0);

        repeat (3) @(negedge CLK);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
